// File: rtl/salamander_pkg.sv
// Shared Salamander-4 types and default widths used by PC, fetch and decode.
package salamander_pkg;

  localparam int unsigned DEFAULT_ADDR_W  = 5;
  localparam int unsigned DEFAULT_INSTR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DRAIN_H,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Small instruction buffer between program memory and decode.
// Head data is read straight from storage; clear empties it in one edge.
module instr_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned INSTR_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [INSTR_W-1:0]       wdata,
  output logic [INSTR_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Salamander-4 fetch stage: issues PC-addressed reads, buffers returned words
// and hands them to decode over valid/ready; stops on disable, pc_max or flush.
module instr_fetch
  import salamander_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned INSTR_W = DEFAULT_INSTR_W,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_val,
  input  logic               pc_max,
  output logic               pc_inc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q;
  logic          rd_pending_q;
  logic          halted_q;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          issue;

  // Credit check counts the in-flight read so the buffer can never overflow.
  assign pop   = instr_valid & instr_ready;
  assign occ   = count + CW'(rd_pending_q) - CW'(pop);
  assign issue = (state_q == RUN) & en & ~pc_max & ~flush & (occ < CW'(DEPTH));
  assign push  = rd_pending_q & ~flush;

  assign mem_addr    = pc_val;
  assign mem_rd      = issue;
  assign pc_inc      = issue;
  assign instr_valid = ~empty;
  assign halted      = halted_q;

  instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (mem_rdata),
    .rdata (instr_out),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Fetch control; flush only redirects HALT, other states keep their own exits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rd_pending_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      rd_pending_q <= issue;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q  <= pc_max ? HALT : RUN;
            halted_q <= pc_max;
          end
        end
        RUN: begin
          if (!en)        state_q <= DRAIN;
          else if (pc_max) state_q <= DRAIN_H;
        end
        DRAIN: begin
          if (!rd_pending_q) state_q <= IDLE;
        end
        DRAIN_H: begin
          if (!rd_pending_q) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (flush) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (rstn && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC/ROM environment plus a queue-based reference model.
module tb_instr_fetch;

  localparam int AW    = 5;
  localparam int IW    = 8;
  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DRAIN_H = 3, M_HALT = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          pc_max = 1'b0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc_val;
  logic          pc_inc;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          halted;

  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;
  logic [IW-1:0] rom [32];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [IW-1:0] mq[$];
  bit            m_pend;
  logic [IW-1:0] m_pend_word;
  int            m_state;
  bit            m_halted;

  // Values sampled by the most recent cycle
  logic          s_rd, s_valid, s_halted;
  logic [IW-1:0] s_out;
  logic [AW-1:0] s_addr;

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .flush       (flush),
    .pc_val      (pc_val),
    .pc_max      (pc_max),
    .pc_inc      (pc_inc),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn)        pc_val <= '0;
    else if (pc_load) pc_val <= pc_load_val;
    else if (pc_inc)  pc_val <= pc_val + 5'd1;
  end

  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  task automatic model_reset();
    mq.delete();
    m_pend   = 1'b0;
    m_pend_word = '0;
    m_state  = M_IDLE;
    m_halted = 1'b0;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic cycle(input string tag);
    bit exp_valid, exp_rd, pop, old_pend;
    int occ;
    @(negedge clk);
    exp_valid = (mq.size() > 0);
    pop       = exp_valid && instr_ready;
    occ       = mq.size() + int'(m_pend) - int'(pop);
    exp_rd    = (m_state == M_RUN) && en && !pc_max && !flush && (occ < DEPTH);
    s_rd = mem_rd; s_valid = instr_valid; s_out = instr_out;
    s_addr = mem_addr; s_halted = halted;
    vectors++;
    if (instr_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL %s instr_valid: got %b expected %b", tag, instr_valid, exp_valid);
    end
    if (exp_valid) begin
      vectors++;
      if (instr_out !== mq[0]) begin
        miscompares++;
        $display("FAIL %s instr_out: got %h expected %h", tag, instr_out, mq[0]);
      end
    end
    vectors++;
    if (mem_rd !== exp_rd) begin
      miscompares++;
      $display("FAIL %s mem_rd: got %b expected %b", tag, mem_rd, exp_rd);
    end
    vectors++;
    if (pc_inc !== exp_rd) begin
      miscompares++;
      $display("FAIL %s pc_inc: got %b expected %b", tag, pc_inc, exp_rd);
    end
    vectors++;
    if (mem_addr !== pc_val) begin
      miscompares++;
      $display("FAIL %s mem_addr: got %h expected %h", tag, mem_addr, pc_val);
    end
    vectors++;
    if (halted !== m_halted) begin
      miscompares++;
      $display("FAIL %s halted: got %b expected %b", tag, halted, m_halted);
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_word);
    end
    old_pend = m_pend;
    case (m_state)
      M_IDLE:    if (en) m_state = pc_max ? M_HALT : M_RUN;
      M_RUN:     if (!en) m_state = M_DRAIN; else if (pc_max) m_state = M_DRAIN_H;
      M_DRAIN:   if (!old_pend) m_state = M_IDLE;
      M_DRAIN_H: if (!old_pend) m_state = M_HALT;
      M_HALT:    if (flush) m_state = M_IDLE;
      default:   m_state = M_IDLE;
    endcase
    m_halted    = (m_state == M_HALT);
    m_pend      = exp_rd;
    m_pend_word = rom[pc_val];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({instr_valid, halted, mem_rd, pc_inc} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {instr_valid, halted, mem_rd, pc_inc});
    end
    vectors++;
    if (instr_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_instr_out: got %h expected 00", instr_out);
    end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    en = 1'b1; instr_ready = 1'b1;
    cycle("stream_c0");
    cycle("stream_c1");
    vectors++;
    if (s_rd !== 1'b1 || s_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL stream_first_issue: got rd=%b addr=%h expected rd=1 addr=00", s_rd, s_addr);
    end
    cycle("stream_c2");
    for (int i = 0; i < 10; i++) begin
      cycle("stream");
      vectors++;
      if (s_valid !== 1'b1 || s_out !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("FAIL stream_word%0d: got valid=%b out=%h expected valid=1 out=%h",
                 i, s_valid, s_out, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] prev;
    bit have_prev;
    instr_ready = 1'b0;
    repeat (4) cycle("bp_stall");
    vectors++;
    if (s_rd !== 1'b0 || s_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: got rd=%b valid=%b expected rd=0 valid=1", s_rd, s_valid);
    end
    instr_ready = 1'b1;
    have_prev = 1'b0;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      cycle("bp_drain");
      if (s_valid) begin
        if (have_prev) begin
          vectors++;
          if (s_out !== 8'(prev + 8'd1)) begin
            miscompares++;
            $display("FAIL bp_order: got %h expected %h", s_out, 8'(prev + 8'd1));
          end
        end
        prev = s_out;
        have_prev = 1'b1;
      end
    end
  endtask

  task automatic test_flush();
    bit found = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_pend && mq.size() > 0) found = 1'b1;
      else cycle("flush_prep");
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flush_setup: got no pending read expected pending with data buffered");
    end
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 5'h0C;
    cycle("flush_edge");
    flush = 1'b0; pc_load = 1'b0; instr_ready = 1'b1;
    cycle("flush_c1");
    vectors++;
    if (s_valid !== 1'b0 || s_rd !== 1'b1 || s_addr !== 5'h0C) begin
      miscompares++;
      $display("FAIL flush_resume: got valid=%b rd=%b addr=%h expected valid=0 rd=1 addr=0c",
               s_valid, s_rd, s_addr);
    end
    cycle("flush_c2");
    cycle("flush_c3");
    vectors++;
    if (s_valid !== 1'b1 || s_out !== 8'h1C) begin
      miscompares++;
      $display("FAIL flush_first_word: got valid=%b out=%h expected valid=1 out=1c", s_valid, s_out);
    end
  endtask

  task automatic test_halt();
    instr_ready = 1'b0;
    cycle("halt_prep");
    pc_max = 1'b1;
    cycle("halt_enter");
    vectors++;
    if (s_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_no_issue: got rd=%b expected 0", s_rd);
    end
    cycle("halt_drain_h");
    cycle("halt_c2");
    vectors++;
    if (s_halted !== 1'b1 || s_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_state: got halted=%b valid=%b expected halted=1 valid=1", s_halted, s_valid);
    end
    instr_ready = 1'b1;
    repeat (4) cycle("halt_deliver");
    vectors++;
    if (s_halted !== 1'b1 || s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_drained: got halted=%b valid=%b expected halted=1 valid=0", s_halted, s_valid);
    end
    flush = 1'b1; pc_max = 1'b0; pc_load = 1'b1; pc_load_val = 5'h02;
    cycle("halt_flush");
    flush = 1'b0; pc_load = 1'b0;
    cycle("halt_after_flush");
    vectors++;
    if (s_halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_cleared: got halted=%b expected 0", s_halted);
    end
  endtask

  task automatic test_disable();
    bit found = 1'b0;
    int pulses = 0;
    instr_ready = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle("dis_prep");
      if (s_rd) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL dis_setup: got no issue expected a read in flight");
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle("dis");
      if (s_rd) pulses++;
    end
    vectors++;
    if (pulses != 0 || s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dis_quiet: got pulses=%0d valid=%b expected pulses=0 valid=0", pulses, s_valid);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; instr_ready = 1'b0;
    repeat (4) cycle("ar_fill");
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({instr_valid, halted, mem_rd, pc_inc} !== 4'b0000 || instr_out !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got flags=%b out=%h expected flags=0000 out=00",
               {instr_valid, halted, mem_rd, pc_inc}, instr_out);
    end
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    instr_ready = 1'b1;
    cycle("ar_c0");
    cycle("ar_c1");
    vectors++;
    if (s_rd !== 1'b1 || s_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL ar_restart: got rd=%b addr=%h expected rd=1 addr=00", s_rd, s_addr);
    end
    cycle("ar_c2");
    cycle("ar_c3");
    vectors++;
    if (s_valid !== 1'b1 || s_out !== 8'h10) begin
      miscompares++;
      $display("FAIL ar_latency: got valid=%b out=%h expected valid=1 out=10", s_valid, s_out);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 32; a++) rom[a] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      instr_ready = 1'($urandom);
      flush       = ($urandom_range(0, 19) == 0);
      pc_load     = flush;
      pc_load_val = 5'($urandom);
      pc_max      = ($urandom_range(0, 29) == 0);
      cycle("random");
    end
    flush = 1'b0; pc_load = 1'b0; pc_max = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) rom[a] = 8'(8'h10 + a);
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_halt();
    test_disable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the Salamander-4 core, and the consumer of the program counter.
- Reads the PC value, issues synchronous reads to program memory, and pulses the PC increment for each read it issues.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Stops fetching on PC max-size-reached, on disable, or on flush (jump).

Parameters:
ADDR_W, 5, program address width; matches the PC SIZE.
INSTR_W, 8, instruction word width.
DEPTH, 2, instruction buffer entries (≥2, power of 2).

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
en  in  1  fetch enable
flush  in  1  discard buffered and in-flight instructions (jump/redirect)
pc_val  in  ADDR_W  current PC value
pc_max  in  1  PC max-size-reached flag
pc_inc  out  1  increment request to PC
mem_addr  out  ADDR_W  program memory address
mem_rd  out  1  program memory read strobe
mem_rdata  in  INSTR_W  read data, valid the cycle after mem_rd
instr_out  out  INSTR_W  instruction at the buffer head
instr_valid  out  1  buffer non-empty
instr_ready  in  1  decode accepts instr_out
halted  out  1  fetch halted by pc_max

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, FIFO empty, rd_pending_q=0.
  - instr_valid=0, instr_out=0, halted=0, mem_rd=0, pc_inc=0.
- mem_addr = pc_val at all times (combinational). pc_inc = mem_rd.
  - The PC advances on the same edge at which memory samples the address.
- pop = instr_valid & instr_ready. occ = count + rd_pending_q − pop.
- Issue condition, evaluated combinationally each cycle:
  - mem_rd = (state==RUN) & en & !pc_max & !flush & (occ < DEPTH).
- rd_pending_q <= mem_rd.
  - When rd_pending_q=1 and flush=0, mem_rdata is pushed into the FIFO at the next edge.
- FIFO behaviour:
  - No bypass: the issue-to-instr_valid latency is exactly 2 cycles.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the credit rule; a push while full is an assertion failure.
- flush priority: highest.
  - At the edge, the FIFO is cleared and any pending return is discarded (not pushed). rd_pending_q <= 0.
  - No issue occurs in the flush cycle; next-cycle instr_valid=0.
  - Fetch resumes the following cycle at the new pc_val if state==RUN.
- FSM (fetch_state_t):
  - IDLE: no issue. en=1 & !pc_max → RUN. en=1 & pc_max → HALT.
  - RUN: issue per rule. en=0 → DRAIN. pc_max=1 → DRAIN_H.
  - DRAIN: no issue; once rd_pending_q=0 → IDLE.
  - DRAIN_H: no issue; once rd_pending_q=0 → HALT.
  - HALT: halted=1 (registered, set on entry); no issue. flush → IDLE with halted cleared.
- Buffered instructions still drain to decode in IDLE, DRAIN, DRAIN_H and HALT.
- Simultaneous events:
  - flush together with an en/pc_max change: flush applies, then FSM transitions apply.
  - Reset mid-read: the returning data is ignored.
- Width rules:
  - count is $clog2(DEPTH)+1 bits.
  - occ is computed at count width with no underflow (pop implies count≥1).

Decomposition:
- Shared package salamander_pkg holds:
  - fetch_state_t enum {IDLE, RUN, DRAIN, DRAIN_H, HALT}.
  - Default ADDR_W and INSTR_W localparams, shared with PC and decode.
- One sub-module: instr_fifo.
  - Parameters DEPTH and INSTR_W; push/pop/clear; count, head data, empty/full.
  - Async active-low reset.

Test Plan:
1. Streaming: reset, ROM[a]=0x10+a, en=1 and instr_ready=1 from cycle 0.
   - mem_rd and pc_inc at cycle 1 with mem_addr=0.
   - instr_valid at cycle 3 with instr_out=0x10, then 0x11, 0x12… one per cycle, no gaps.
2. Backpressure: instr_ready=0 during streaming.
   - FIFO fills to 2, and mem_rd/pc_inc drop to 0 in the same cycle occ reaches 2.
   - Raise ready: order is 0x10, 0x11… with no duplicates or loss.
3. Flush: assert flush with the FIFO full and rd_pending_q=1.
   - Next cycle instr_valid=0 and count=0; the pending word never appears.
   - Next issued mem_addr = new pc_val (e.g. 0x0C → first instr_out 0x1C).
4. Halt: pc_max=1 while in RUN.
   - mem_rd=0 in that cycle; state DRAIN_H, then HALT; halted=1.
   - Buffered words still delivered; flush returns the FSM to IDLE and clears halted.
5. Disable: en=0 with a read in flight.
   - The in-flight word is pushed; FSM DRAIN → IDLE; zero further pc_inc pulses.
6. Async reset mid-stream: rstn low between edges.
   - All outputs reach their reset values immediately.
   - After release with en=1, fetch restarts at pc_val=0 with latency 2.
